// File: rtl/booth_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : booth_mul_sequencer
// Description : Operand feeder, done/timeout sequencer and 2-entry result FIFO
//               wrapped around a start/done Booth multiplier core.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mul_sequencer #(
    parameter int N       = 16,
    parameter int TIMEOUT = 64,
    parameter int DEPTH   = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    output logic           mul_start,
    output logic [N-1:0]   mul_multiplicand,
    output logic [N-1:0]   mul_multiplier,
    input  logic [2*N-1:0] mul_product,
    input  logic           mul_done,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_product,
    output logic           busy,
    output logic           timeout_err
);

    localparam int c_TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = c_PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_ready_en;
    logic [c_TW-1:0]   r_timer;
    logic              r_timeout_err;
    logic              r_mul_start;
    logic [N-1:0]      r_mcand;
    logic [N-1:0]      r_mplier;

    logic [2*N-1:0]    r_mem [DEPTH];
    logic [c_PW-1:0]   r_wr_ptr;
    logic [c_PW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_done_ok;
    logic              w_timeout;
    logic              w_push;
    logic              w_pop;

    // r_ready_en keeps in_ready low until the first edge after reset release.
    assign w_in_ready = r_ready_en && (r_state == S_IDLE) && (r_count < c_CW'(DEPTH));
    assign w_accept   = in_valid && w_in_ready;
    // A done seen while the timer is still zero may be left over from the last op.
    assign w_done_ok  = (r_state == S_WAIT) && mul_done && (r_timer != '0);
    assign w_timeout  = (r_state == S_WAIT) && !w_done_ok && (r_timer == c_TW'(TIMEOUT - 1));
    assign w_push     = w_done_ok;
    assign w_pop      = (r_count != '0) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_ready_en    <= 1'b0;
            r_timer       <= '0;
            r_timeout_err <= 1'b0;
            r_mul_start   <= 1'b0;
            r_mcand       <= '0;
            r_mplier      <= '0;
        end else begin
            r_ready_en  <= 1'b1;
            r_mul_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mcand     <= in_a;
                        r_mplier    <= in_b;
                        r_mul_start <= 1'b1;
                        r_state     <= S_START;
                    end
                end
                S_START: begin
                    r_timer <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_timer <= r_timer + c_TW'(1);
                    if (w_done_ok) begin
                        r_state <= S_IDLE;
                    end else if (w_timeout) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= mul_product;
                r_wr_ptr        <= r_wr_ptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign in_ready         = w_in_ready;
    assign mul_start        = r_mul_start;
    assign mul_multiplicand = r_mcand;
    assign mul_multiplier   = r_mplier;
    assign out_valid        = (r_count != '0);
    assign out_product      = r_mem[r_rd_ptr];
    assign busy             = (r_state != S_IDLE);
    assign timeout_err      = r_timeout_err;

endmodule
`default_nettype wire

// File: doc/booth_mul_sequencer.md
Name: booth_mul_sequencer

Overview:
- Upstream feeder and downstream collector for the Booth multiplier core (start/done, no reset, one operation at a time).
- Accepts signed operand pairs on a valid/ready stream and holds them stable on the core inputs.
- Issues a one-cycle start, waits for done, and captures the 2N-bit product into a 2-entry output FIFO with valid/ready.
- Adds reset and a done-timeout, which the core itself lacks.

Parameters:
- N, 16, operand width; product is 2N.
- TIMEOUT, 64, maximum cycles in WAIT before abandoning an operation.
- DEPTH, 2, output FIFO entries (fixed at 2; must be a power of two).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept a pair.
- in_a  in  N  signed multiplicand.
- in_b  in  N  signed multiplier.
- mul_start  out  1  start pulse to core.
- mul_multiplicand  out  N  held multiplicand to core.
- mul_multiplier  out  N  held multiplier to core.
- mul_product  in  2N  core product.
- mul_done  in  1  core done.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_product  out  2N  FIFO head product, signed.
- busy  out  1  operation in flight (state != IDLE).
- timeout_err  out  1  sticky; set on timeout, cleared only by reset.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; FIFO is emptied; timer is cleared.
  - All outputs are 0: in_ready, mul_start, mul_multiplicand, mul_multiplier, out_valid, out_product, busy, timeout_err.
  - in_ready rises on the first clk edge after rst_n deasserts.
- States: IDLE, START, WAIT. A completion pushes into the FIFO and returns to IDLE in the same edge.
- IDLE:
  - in_ready = (fifo_count < DEPTH); combinational from registered state and count only, never from out_ready.
  - On in_valid && in_ready: register in_a/in_b into mul_multiplicand/mul_multiplier, then go to START.
- START:
  - mul_start = 1 for exactly this cycle; timer cleared; next state WAIT.
  - Operands stay unchanged until the next acceptance.
- WAIT:
  - Timer increments each cycle.
  - mul_done is ignored in the first WAIT cycle (guard against a stale done level from the previous operation).
  - From the second WAIT cycle on, mul_done=1 pushes mul_product into the FIFO and returns to IDLE.
  - If the timer reaches TIMEOUT-1 with no qualifying done: set timeout_err, push nothing, return to IDLE.
- A done arriving in IDLE or START is ignored.
- Latency:
  - Acceptance edge at cycle 0; mul_start high in cycle 1.
  - out_valid rises the cycle after the edge that samples a qualifying mul_done (when the FIFO was empty).
- FIFO:
  - 2 entries, registered, in order.
  - out_valid = (count != 0); out_product = head entry; out_product holds its value while out_valid && !out_ready.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Overflow is impossible: only one operation is in flight, and acceptance requires count < DEPTH.
- Arithmetic: the product passes through bit-exact (two's complement); no width change, sign or rounding.
- Reset mid-operation (START or WAIT): the operation is abandoned and its result never appears. A late mul_done after reset arrives in IDLE and is ignored.
- Only one operation is ever in flight; in_ready = 0 in START and WAIT.

Test Plan:
- Model core asserts done as a 1-cycle pulse, N+2 cycles after start.
- Basic ops, in_a=3, in_b=-5 -> one mul_start pulse; out_product=0xFFFFFFF1, out_valid within N+4 cycles; then in_a=-32768, in_b=-32768 -> 0x40000000.
- Backpressure, out_ready=0, three pairs offered (7×9, -1×1, 2×2):
  - Two results are stored (0x0000003F, 0xFFFFFFFF) and in_ready stays 0 in IDLE.
  - Raising out_ready drains in order, then accepts the third -> 0x00000004.
  - Drain with out_ready held 1 shows same-cycle push/pop without loss.
- Stale done: mul_done held 1 continuously -> capture occurs only in the second WAIT cycle; exactly one product is pushed per operation.
- Timeout, mul_done never asserted -> timeout_err=1 once TIMEOUT-1 is reached in WAIT, out_valid stays 0, in_ready=1 next cycle; timeout_err stays 1 through later successful ops.
- Reset mid-WAIT: rst_n low for 2 cycles, then a done pulse -> FIFO empty, out_valid=0, busy=0, all outputs 0 during reset; next op 5×6 -> 0x0000001E.
